fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC, issues instruction reads, and

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage_if_id_latch.sv | 20 ++
 rtl/fetch_stage.sv | 55 +++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types (word, PC source select, fetch FSM state, IF/ID latch contents)
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_J, PC_JR} pcsrc_t;
   typedef enum logic [1:0] {RUN, REDIR, HALTED} fetch_state_t;
   typedef struct packed {
      word_t instr;
      word_t npc;
      logic  valid;
   } if_id_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem, hazard, redirect and IF/ID signals of the fetch stage
//  master: fetch_stage side (drives imemREN/imemaddr and the IF/ID outputs)
//  slave : surrounding pipeline/memory side
interface fetch_stage_if;
   import cpu_types_pkg::*;
   logic   ihit;
   word_t  imemload;
   logic   imemREN;
   word_t  imemaddr;
   logic   pc_hold;
   logic   enable_ID;
   logic   flush_ID;
   pcsrc_t pcsrc;
   word_t  branch_tgt;
   word_t  jump_tgt;
   word_t  jr_tgt;
   logic   halt;
   word_t  instr_ID;
   word_t  npc_ID;
   logic   valid_ID;
   modport master (
      input  ihit, imemload, pc_hold, enable_ID, flush_ID, pcsrc,
             branch_tgt, jump_tgt, jr_tgt, halt,
      output imemREN, imemaddr, instr_ID, npc_ID, valid_ID
   );
   modport slave (
      output ihit, imemload, pc_hold, enable_ID, flush_ID, pcsrc,
             branch_tgt, jump_tgt, jr_tgt, halt,
      input  imemREN, imemaddr, instr_ID, npc_ID, valid_ID
   );
endinterface

// File: rtl/fetch_stage_if_id_latch.sv
// if_id_latch: IF/ID pipeline register with flush (wins) and load enable
//  CLK, nRST : clock, async active-low reset
//  flush     : clear to bubble
//  en        : load d (otherwise hold)
//  d, q      : next / current latch contents
module if_id_latch
   import cpu_types_pkg::*;
(
   input  logic   CLK,
   input  logic   nRST,
   input  logic   flush,
   input  logic   en,
   input  if_id_t d,
   output if_id_t q
);
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) q <= '0;
      else if (flush) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, imem read requests and the IF/ID latch
//  CLK, nRST : clock, async active-low reset
//  fif       : fetch_stage_if.master (imem, hazard controls, redirect targets, halt, IF/ID outputs)
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
)(
   input  logic CLK,
   input  logic nRST,
   fetch_stage_if.master fif
);
   fetch_state_t state;
   word_t        pc, pc4, tgt;
   logic         redirect, freeze, advance, load;
   if_id_t       d, q;
   assign pc4      = pc + 32'd4;
   assign redirect = fif.pcsrc != PC_SEQ;
   assign tgt      = fif.pcsrc == PC_BR ? fif.branch_tgt :
                     fif.pcsrc == PC_J  ? fif.jump_tgt : fif.jr_tgt;
   // halt takes effect on the edge it is seen, so PC and latch freeze immediately
   assign freeze   = fif.halt | (state == HALTED);
   assign advance  = (state == RUN) & fif.ihit & ~fif.pc_hold & fif.enable_ID;
   // in REDIR any ihit belongs to the stale address, so only RUN may load
   assign load     = (state == RUN) & fif.ihit & ~redirect & ~fif.pc_hold;
   assign d        = load ? if_id_t'{instr: fif.imemload, npc: pc4, valid: 1'b1} : '0;
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         pc    <= PC_INIT;
         state <= RUN;
      end else if (freeze) begin
         state <= HALTED;
      end else if (redirect) begin
         pc    <= tgt;
         // a read already returning for the old PC lets us resume directly;
         // otherwise the in-flight response must be skipped in REDIR
         state <= (state == REDIR || !fif.ihit) ? REDIR : RUN;
      end else begin
         if (advance) pc <= pc4;
         state <= RUN;
      end
   if_id_latch u_latch (
      .CLK   (CLK),
      .nRST  (nRST),
      .flush (fif.flush_ID & ~freeze),
      .en    (fif.enable_ID & ~freeze),
      .d     (d),
      .q     (q)
   );
   assign fif.imemREN  = nRST & (state != HALTED);
   assign fif.imemaddr = pc;
   assign fif.instr_ID = q.instr;
   assign fif.npc_ID   = q.npc;
   assign fif.valid_ID = q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test of fetch_stage against a behavioural model plus literal checks
module tb_fetch_stage;
   import cpu_types_pkg::*;
   logic clk = 0;
   logic nrst = 1;
   int   n_cmp = 0;
   int   n_bad = 0;
   fetch_stage_if fif();
   fetch_stage #(.PC_INIT(32'h0)) dut (.CLK(clk), .nRST(nrst), .fif(fif));
   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask
   // model: mode 0 = fetching, 1 = skipping the stale response after a redirect, 2 = halted
   int    m_mode  = 0;
   word_t m_pc    = 0;
   word_t m_instr = 0;
   word_t m_npc   = 0;
   logic  m_valid = 0;
   initial forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
         m_mode = 0; m_pc = 0; m_instr = 0; m_npc = 0; m_valid = 0;
      end else if (m_mode == 2 || fif.halt) begin
         m_mode = 2;
      end else begin
         word_t target;
         bit    jump, fresh;
         jump   = fif.pcsrc != PC_SEQ;
         target = fif.pcsrc == PC_BR ? fif.branch_tgt : fif.pcsrc == PC_J ? fif.jump_tgt : fif.jr_tgt;
         fresh  = m_mode == 0 && fif.ihit && !jump && !fif.pc_hold;
         if (fif.flush_ID) begin
            m_instr = 0; m_npc = 0; m_valid = 0;
         end else if (fif.enable_ID) begin
            m_instr = fresh ? fif.imemload : 0;
            m_npc   = fresh ? m_pc + 4 : 0;
            m_valid = fresh;
         end
         if (jump) begin
            m_mode = (m_mode == 1 || !fif.ihit) ? 1 : 0;
            m_pc   = target;
         end else begin
            if (m_mode == 0 && fif.ihit && !fif.pc_hold && fif.enable_ID) m_pc = m_pc + 4;
            m_mode = 0;
         end
      end
   end
   initial forever begin
      @(negedge clk);
      chk("cyc_ren", {31'b0, fif.imemREN}, {31'b0, nrst && m_mode != 2});
      chk("cyc_addr", fif.imemaddr, m_pc);
      chk("cyc_valid", {31'b0, fif.valid_ID}, {31'b0, m_valid});
      chk("cyc_instr", fif.instr_ID, m_instr);
      if (m_valid) chk("cyc_npc", fif.npc_ID, m_npc);
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle;
      fif.ihit = 0; fif.imemload = 0; fif.pc_hold = 0; fif.enable_ID = 1; fif.flush_ID = 0;
      fif.pcsrc = PC_SEQ; fif.branch_tgt = 0; fif.jump_tgt = 0; fif.jr_tgt = 0; fif.halt = 0;
   endtask
   word_t stream [4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
   initial begin
      idle();
      #1 nrst = 0;
      repeat (2) tick();
      chk("rst_ren", {31'b0, fif.imemREN}, 0);
      chk("rst_addr", fif.imemaddr, 0);
      chk("rst_valid", {31'b0, fif.valid_ID}, 0);
      nrst = 1;
      fif.ihit = 1; fif.imemload = 32'h1111_1111;
      repeat (2) tick();
      chk("pre_addr", fif.imemaddr, 32'h8);
      chk("pre_valid", {31'b0, fif.valid_ID}, 1);
      #3 nrst = 0;
      #1;
      chk("async_addr", fif.imemaddr, 0);
      chk("async_valid", {31'b0, fif.valid_ID}, 0);
      chk("async_ren", {31'b0, fif.imemREN}, 0);
      tick();
      nrst = 1;
      for (int i = 0; i < 4; i++) begin
         fif.imemload = stream[i];
         tick();
         chk("stream_instr", fif.instr_ID, stream[i]);
         chk("stream_npc", fif.npc_ID, 32'(4 * (i + 1)));
      end
      fif.pc_hold = 1; fif.enable_ID = 0; fif.imemload = 32'hEEEE_EEEE;
      repeat (2) begin
         tick();
         chk("stall_addr", fif.imemaddr, 32'h10);
         chk("stall_instr", fif.instr_ID, 32'hDDDD_0004);
      end
      fif.pc_hold = 0; fif.enable_ID = 1; fif.imemload = 32'h0E0E_0E0E;
      tick();
      chk("release_npc", fif.npc_ID, 32'h14);
      chk("release_instr", fif.instr_ID, 32'h0E0E_0E0E);
      fif.pcsrc = PC_J; fif.jump_tgt = 32'h400; fif.pc_hold = 1; fif.flush_ID = 1;
      tick();
      chk("jump_addr", fif.imemaddr, 32'h400);
      chk("jump_valid", {31'b0, fif.valid_ID}, 0);
      idle();
      fif.pcsrc = PC_BR; fif.branch_tgt = 32'h80;
      tick();
      chk("br_addr", fif.imemaddr, 32'h80);
      fif.pcsrc = PC_SEQ; fif.ihit = 1; fif.imemload = 32'hDEAD_BEEF;
      tick();
      chk("stale_valid", {31'b0, fif.valid_ID}, 0);
      chk("stale_addr", fif.imemaddr, 32'h80);
      fif.imemload = 32'hF00D_0001;
      tick();
      chk("br_npc", fif.npc_ID, 32'h84);
      chk("br_instr", fif.instr_ID, 32'hF00D_0001);
      fif.pcsrc = PC_JR; fif.jr_tgt = 32'hFFFF_FFFC;
      tick();
      chk("wrap_pre", fif.imemaddr, 32'hFFFF_FFFC);
      fif.pcsrc = PC_SEQ; fif.imemload = 32'h6666_6666;
      tick();
      chk("wrap_addr", fif.imemaddr, 32'h0);
      chk("wrap_npc", fif.npc_ID, 32'h0);
      fif.imemload = 32'h7777_7777;
      tick();
      chk("post_wrap", fif.imemaddr, 32'h4);
      fif.halt = 1; fif.pcsrc = PC_JR; fif.jr_tgt = 32'h999; fif.imemload = 32'h8888_8888;
      tick();
      fif.halt = 0; fif.pcsrc = PC_SEQ;
      repeat (5) begin
         tick();
         chk("halt_ren", {31'b0, fif.imemREN}, 0);
         chk("halt_addr", fif.imemaddr, 32'h4);
         chk("halt_instr", fif.instr_ID, 32'h7777_7777);
      end
      #3 nrst = 0;
      #1 chk("halt_rst_addr", fif.imemaddr, 0);
      tick();
      nrst = 1;
      fif.imemload = 32'h9999_9999;
      tick();
      chk("restart_instr", fif.instr_ID, 32'h9999_9999);
      chk("restart_ren", {31'b0, fif.imemREN}, 1);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
